// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit add/subtract built from one full-adder
// cell and a carry flop. Operands are consumed LSB first, one bit per clock;
// the parallel result and carry-out are published only when all bits are done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] shs_q, shs_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] shs_nxt;

  // Full-adder cell fed by the current LSBs and the registered carry.
  always_comb begin
    s_bit   = sha_q[0] ^ shb_q[0] ^ c_q;
    c_nxt   = (sha_q[0] & shb_q[0]) | (sha_q[0] & c_q) | (shb_q[0] & c_q);
    shs_nxt = {s_bit, shs_q[WIDTH-1:1]};
  end

  // Next-state and datapath control; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shs_d   = shs_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so cin is replaced by the forced 1.
          sha_d   = a;
          shb_d   = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sha_d = sha_q >> 1;
        shb_d = shb_q >> 1;
        shs_d = shs_nxt;
        c_d   = c_nxt;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the full word; counter holds instead of wrapping.
          sum_d   = shs_nxt;
          cout_d  = c_nxt;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sha_q   <= '0;
      shb_q   <= '0;
      shs_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shs_q   <= shs_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder/subtractor built around a single full-adder cell and a carry flip-flop.
- Consumes one operand bit-pair per clock, LSB first, and feeds the full adder with the registered carry.
- Produces a registered parallel sum and carry-out, with a start/busy/done handshake.
- Sits as the sequential stage directly above the combinational full adder and turns it into a multi-bit datapath element for the lab ALU.

Parameters:
- WIDTH, 8, operand and sum width in bits (≥2).

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      synchronous active-low reset
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  operand A; captured on the accepted start edge
- b      input   WIDTH  operand B; captured on the accepted start edge
- cin    input   1      carry-in; captured on the start edge; ignored when sub=1
- sub    input   1      1 = compute a − b as a + ~b + 1; captured on the start edge
- busy   output  1      high while bits are being processed (RUN)
- done   output  1      one-cycle pulse; result valid
- sum    output  WIDTH  result register
- cout   output  1      final carry (for sub: 1 = no borrow)

Behaviour:
- Reset: rst_n sampled low at a rising edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, and clears the bit counter, carry FF and shift registers. Reset overrides start and any in-flight operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load shA=a; load shB=(sub ? ~b : b); carry FF = (sub ? 1 : cin); clear cnt; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge: s_bit = shA[0]^shB[0]^c; c <= majority(shA[0], shB[0], c).
  - shA and shB shift right by 1. s_bit shifts into the MSB of the partial-sum register shS.
  - cnt increments.
  - On the edge where cnt==WIDTH−1: sum <= {s_bit, shS[WIDTH-1:1]}; cout <= new carry; go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditional return to IDLE. start during DONE is ignored.
- Latency:
  - Load edge = E0.
  - Bits are processed on E1..EWIDTH.
  - done is high in the cycle after EWIDTH.
  - The next start is accepted at the earliest at EWIDTH+2.
- sum/cout update only on completion. No partial value is ever visible. They hold their value until the next completion or reset.
- start while busy or done: ignored; operands are not re-sampled.
- Operand inputs may change freely after the load edge without affecting the result.
- Arithmetic: sum = (a + b' + c0) mod 2^WIDTH, and cout = bit WIDTH of that sum, where:
  - b' = sub ? ~b : b
  - c0 = sub ? 1 : cin
- cnt is ceil(log2(WIDTH)) bits and never wraps past WIDTH−1.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, sub=0, start pulse -> busy high 8 cycles; done pulse after E8; sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
3. sub=1: a=0x10, b=0x01 (cin=1 ignored) -> sum=0x0F, cout=1. Then a=0x01, b=0x02 -> sum=0xFF, cout=0 (borrow).
4. Start a=0x11, b=0x22; at E3 assert start with a=0xFF, b=0xFF and change the operand inputs -> result still sum=0x33; done pulses once, at E8+.
5. Start a=0x0F, b=0x01; drive rst_n=0 at E4 -> next cycle busy=0, done=0, sum=0x00, cout=0. After release, a new start a=0x02, b=0x03 -> sum=0x05.
6. Hold start=1 continuously with a=0x01, b=0x01 -> back-to-back operations start every WIDTH+2 edges; each done pulse is 1 cycle wide; sum=0x02 each time.
